// File: rtl/uart_transmitter.sv
// UART transmitter: sends a payload byte followed by its CRC-8 byte
// as two back-to-back 8N1 frames, LSB first, idle-high line.
module uart_transmitter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] crc_in,
    input  logic       tx_start,
    output logic       tx_out,
    output logic       tx_busy
);

    // Must be at least 2 for the cycle counter to be meaningful.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             byte_sel_q, byte_sel_d;
    logic [7:0]       data_sr_q, data_sr_d;
    logic [7:0]       crc_sr_q, crc_sr_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_busy_q, tx_busy_d;

    logic             bit_end;

    assign bit_end = (clk_cnt_q == CNT_LAST);

    // State register: every flop, cleared asynchronously to a quiet idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            data_sr_q  <= '0;
            crc_sr_q   <= '0;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            data_sr_q  <= data_sr_d;
            crc_sr_q   <= crc_sr_d;
            tx_out_q   <= tx_out_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // Next-state logic: bit timing, bit index, byte select and latching.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        data_sr_d  = data_sr_q;
        crc_sr_d   = crc_sr_q;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (tx_start) begin
                    data_sr_d  = data_in;
                    crc_sr_d   = crc_in;
                    byte_sel_d = 1'b0;
                    state_d    = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA_BITS;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (!byte_sel_q) begin
                        // Payload done: CRC frame follows with no gap.
                        byte_sel_d = 1'b1;
                        state_d    = START_BIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: decoded from the next state so the registered line
    // changes on the same edge as the state it represents.
    always_comb begin
        tx_busy_d = (state_d != IDLE);
        tx_out_d  = 1'b1;
        unique case (state_d)
            IDLE:      tx_out_d = 1'b1;
            START_BIT: tx_out_d = 1'b0;
            DATA_BITS: tx_out_d = byte_sel_d ? crc_sr_d[bit_idx_d]
                                             : data_sr_d[bit_idx_d];
            STOP_BIT:  tx_out_d = 1'b1;
            default:   tx_out_d = 1'b1;
        endcase
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed and random two-frame
// transmissions checked cycle by cycle against an ideal line model.
module tb_uart_transmitter;

    localparam int CLK_FREQ  = 50000000;
    localparam int BAUD_RATE = 1000000;
    localparam int N         = CLK_FREQ / BAUD_RATE;
    localparam int TX_CYC    = 20 * N;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [7:0] crc_in;
    logic       tx_start;
    logic       tx_out;
    logic       tx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_transmitter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .crc_in  (crc_in),
        .tx_start(tx_start),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Ideal line content: bit k of the result is the level of bit period k.
    function automatic logic [19:0] line_bits(input logic [7:0] d,
                                              input logic [7:0] c);
        return {1'b1, c, 1'b0, 1'b1, d, 1'b0};
    endfunction

    // Starts a transmission from an idle negedge and checks every cycle.
    // noise: random tx_start/data during busy; zap: zero inputs after start;
    // hold: keep tx_start high at the end; abort_at: cycle to assert reset.
    task automatic xmit(input logic [7:0] d, input logic [7:0] c,
                        input bit noise, input bit zap, input bit hold,
                        input int abort_at);
        logic [19:0] bits;
        bits     = line_bits(d, c);
        data_in  = d;
        crc_in   = c;
        tx_start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < TX_CYC; k++) begin
            if (k == abort_at) begin
                #3 reset = 1'b0;
                #1 check("abort_async", {tx_busy, tx_out}, 2'b01);
                for (int j = 0; j < 4; j++) begin
                    tx_start = 1'($urandom);
                    @(negedge clk);
                    check("abort_hold", {tx_busy, tx_out}, 2'b01);
                end
                tx_start = 1'b0;
                reset    = 1'b1;
                return;
            end
            check("line", {tx_busy, tx_out}, {1'b1, bits[k / N]});
            if (zap && k == 0) begin
                data_in = 8'h00;
                crc_in  = 8'h00;
            end
            if (noise) begin
                data_in  = 8'($urandom);
                crc_in   = 8'($urandom);
                tx_start = 1'($urandom);
            end else if (!hold) begin
                tx_start = 1'b0;
            end
            if (k == TX_CYC - 1 && !hold) tx_start = 1'b0;
            @(negedge clk);
        end
        check("idle_gap", {tx_busy, tx_out}, 2'b01);
    endtask

    initial begin
        reset    = 1'b0;
        tx_start = 1'b0;
        data_in  = 8'h00;
        crc_in   = 8'h00;
        #100;
        check("rst_out", {tx_busy, tx_out}, 2'b01);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            data_in = 8'($urandom);
            crc_in  = 8'($urandom);
            @(negedge clk);
            check("quiet", {tx_busy, tx_out}, 2'b01);
        end

        xmit(8'h55, 8'hA3, 0, 0, 0, -1);
        xmit(8'hAB, 8'h5F, 0, 1, 0, -1);
        xmit(8'hFF, 8'h00, 0, 0, 0, -1);

        xmit(8'h12, 8'h34, 0, 0, 1, -1);
        xmit(8'hC3, 8'h3C, 0, 0, 1, -1);
        xmit(8'h80, 8'h01, 0, 0, 0, -1);

        xmit(8'hE7, 8'h9D, 0, 0, 0, 13 * N + N / 2);
        xmit(8'h0F, 8'hF0, 0, 0, 0, -1);

        for (int i = 0; i < 16; i++) begin
            xmit(8'($urandom), 8'($urandom), 1, 0,
                 1'($urandom_range(0, 1)), -1);
        end
        tx_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("final_idle", {tx_busy, tx_out}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
